qe_filtered_decoder: RTL

Digital glitch filter and x4 quadrature decoder for one encoder channel. It sits between the input synchronisers and the channel's position, turns and speed counters. It takes synchronised A/B/I levels and produces the one-cycle `count_pulse`, `direction` and `index` signals those counters consume. It also filters contact bounce and EMI glitches with a programmable sample rate, and counts illegal A/B transitions for diagnostics.

---
 rtl/qe_filtered_decoder_pkg.sv | 28 ++
 rtl/qe_filtered_decoder_glitch_filter.sv | 37 +++
 rtl/qe_filtered_decoder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/qe_filtered_decoder_pkg.sv
// Shared types and constants for the filtered quadrature decoder.
// Encoding of qe_ab_state_t is the literal {A,B} level pair.
package qe_filtered_decoder_pkg;

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S10 = 2'b10,
        S11 = 2'b11,
        S01 = 2'b01
    } qe_ab_state_t;

    localparam int   QE_ERR_CNT_MAX = 255;
    localparam logic QE_CW          = 1'b1;
    localparam logic QE_CCW         = 1'b0;

    // Successor of a state when the encoder turns clockwise (A leads B).
    function automatic qe_ab_state_t qe_cw_next(input qe_ab_state_t s);
        qe_ab_state_t n;
        case (s)
            S00:     n = S10;
            S10:     n = S11;
            S11:     n = S01;
            default: n = S00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/qe_filtered_decoder_glitch_filter.sv
// Per-input digital glitch filter: the output follows the raw level only
// after FILTER_DEPTH consecutive differing samples taken on strobe.
module qe_glitch_filter
    import qe_filtered_decoder_pkg::*;
#(
    parameter int FILTER_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    input  logic raw,
    output logic filt
);

    localparam int CNT_W = $clog2(FILTER_DEPTH);

    logic [CNT_W-1:0] run_cnt;

    // The run counter holds how many differing samples have been seen so far;
    // the FILTER_DEPTH-th one commits the new level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cnt <= '0;
            filt    <= 1'b0;
        end else if (strobe) begin
            if (raw == filt) begin
                run_cnt <= '0;
            end else if (run_cnt == CNT_W'(FILTER_DEPTH - 1)) begin
                filt    <= raw;
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/qe_filtered_decoder.sv
// Glitch-filtered x4 quadrature decoder with index and illegal-transition count.
// Build option QE_INDEX_GATE_EN: qualify index rising edges with FSM state S11.
module qe_filtered_decoder
    import qe_filtered_decoder_pkg::*;
#(
    parameter int FILTER_DEPTH = 4,
    parameter int DIV_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] sample_div,
    input  logic             quadA_in,
    input  logic             quadB_in,
    input  logic             quadI_in,
    input  logic             clear_errors,
    output logic             filt_A,
    output logic             filt_B,
    output logic             filt_I,
    output logic             count_pulse,
    output logic             direction,
    output logic             index,
    output logic             error,
    output logic [7:0]       error_count
);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'(QE_ERR_CNT_MAX)) ? v : v + 8'd1;
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic             strobe;

    // Using >= means lowering sample_div below div_cnt strobes on the next clock.
    assign strobe = (div_cnt >= sample_div);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (strobe) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    qe_glitch_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_filt_a (
        .clk    (clk),
        .reset  (reset),
        .strobe (strobe),
        .raw    (quadA_in),
        .filt   (filt_A)
    );

    qe_glitch_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_filt_b (
        .clk    (clk),
        .reset  (reset),
        .strobe (strobe),
        .raw    (quadB_in),
        .filt   (filt_B)
    );

    qe_glitch_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_filt_i (
        .clk    (clk),
        .reset  (reset),
        .strobe (strobe),
        .raw    (quadI_in),
        .filt   (filt_I)
    );

    // Stage p0: filtered levels feeding the decoder.
    qe_ab_state_t ab_p0;
    logic         idx_rise_p0;

    qe_ab_state_t state_p1;
    logic         filt_i_p1;
    logic         vld_p1;
    logic         dir_p1;
    logic         err_p1;
    logic         idx_p1;
    logic [7:0]   err_cnt_p1;

    qe_ab_state_t state_next;
    logic         vld_next;
    logic         dir_next;
    logic         err_next;
    logic         idx_next;
    logic [7:0]   err_cnt_next;

    assign ab_p0       = qe_ab_state_t'({filt_A, filt_B});
    assign idx_rise_p0 = filt_I & ~filt_i_p1;

    always_comb begin
        state_next   = ab_p0;
        vld_next     = 1'b0;
        dir_next     = dir_p1;
        err_next     = 1'b0;
        err_cnt_next = err_cnt_p1;
        idx_next     = 1'b0;

        if (ab_p0 != state_p1) begin
            if (ab_p0 == qe_cw_next(state_p1)) begin
                vld_next = 1'b1;
                dir_next = QE_CW;
            end else if (state_p1 == qe_cw_next(ab_p0)) begin
                vld_next = 1'b1;
                dir_next = QE_CCW;
            end else begin
                // Any other change flips both bits at once.
                err_next     = 1'b1;
                err_cnt_next = sat_inc(err_cnt_p1);
            end
        end

        if (clear_errors) begin
            err_cnt_next = '0;
        end

`ifdef QE_INDEX_GATE_EN
        idx_next = idx_rise_p0 && (state_p1 == S11);
`else
        idx_next = idx_rise_p0;
`endif
    end

    // Stage p1: registered decode; direction changes on the same edge as the pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_p1   <= S00;
            filt_i_p1  <= 1'b0;
            vld_p1     <= 1'b0;
            dir_p1     <= QE_CCW;
            err_p1     <= 1'b0;
            idx_p1     <= 1'b0;
            err_cnt_p1 <= '0;
        end else begin
            state_p1   <= state_next;
            filt_i_p1  <= filt_I;
            vld_p1     <= vld_next;
            dir_p1     <= dir_next;
            err_p1     <= err_next;
            idx_p1     <= idx_next;
            err_cnt_p1 <= err_cnt_next;
        end
    end

    assign count_pulse = vld_p1;
    assign direction   = dir_p1;
    assign error       = err_p1;
    assign index       = idx_p1;
    assign error_count = err_cnt_p1;

endmodule
